on_the_fly_table: RTL and testbench

ON_THE_FLY_TABLE -- requirements
Module: on_the_fly_table

---
 rtl/on_the_fly_table_if.sv | 42 ++++
 rtl/on_the_fly_table.sv | 118 +++++++++++
 tb/tb_on_the_fly_table.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/on_the_fly_table_if.sv
// rtl/on_the_fly_table_if.sv - insert/query/retire bus and status outputs of the pending-transaction table
interface on_the_fly_table_if #(
  parameter int N_BITS_POINTER       = 3,
  parameter int N_BIT_SRC_HEAD_FLIT  = 4,
  parameter int N_BIT_DEST_HEAD_FLIT = 4,
  parameter int N_BIT_CMD_HEAD_FLIT  = 3
);
  logic                            insert_i;
  logic [N_BIT_SRC_HEAD_FLIT-1:0]  insert_sender_i;
  logic [N_BIT_DEST_HEAD_FLIT-1:0] insert_recipient_i;
  logic [N_BIT_CMD_HEAD_FLIT-1:0]  insert_type_i;
  logic                            query_i;
  logic [N_BIT_SRC_HEAD_FLIT-1:0]  query_sender_i;
  logic [N_BIT_DEST_HEAD_FLIT-1:0] query_recipient_i;
  logic [N_BIT_CMD_HEAD_FLIT-1:0]  query_type_i;
  logic                            pending_transaction_executed_i;
  logic                            is_a_pending_transaction_o;
  logic                            full_o;
  logic                            empty_o;
  logic [N_BITS_POINTER:0]         count_o;
  logic                            overflow_o;
  logic                            spurious_exec_o;
  logic                            timeout_o;
  logic [N_BIT_SRC_HEAD_FLIT-1:0]  timeout_sender_o;
  logic [N_BIT_DEST_HEAD_FLIT-1:0] timeout_recipient_o;

  modport slave (
    input  insert_i, insert_sender_i, insert_recipient_i, insert_type_i,
    input  query_i, query_sender_i, query_recipient_i, query_type_i,
    input  pending_transaction_executed_i,
    output is_a_pending_transaction_o, full_o, empty_o, count_o,
    output overflow_o, spurious_exec_o, timeout_o, timeout_sender_o, timeout_recipient_o
  );

  modport master (
    output insert_i, insert_sender_i, insert_recipient_i, insert_type_i,
    output query_i, query_sender_i, query_recipient_i, query_type_i,
    output pending_transaction_executed_i,
    input  is_a_pending_transaction_o, full_o, empty_o, count_o,
    input  overflow_o, spurious_exec_o, timeout_o, timeout_sender_o, timeout_recipient_o
  );
endinterface

// File: rtl/on_the_fly_table.sv
// rtl/on_the_fly_table.sv - table of in-flight NoC requests awaiting a reply, with aging and expiry
module on_the_fly_table #(
  parameter int N_ENTRIES            = 8,
  parameter int N_BITS_POINTER       = 3,
  parameter int N_BITS_TIMEOUT       = 8,
  parameter int N_BIT_SRC_HEAD_FLIT  = 4,
  parameter int N_BIT_DEST_HEAD_FLIT = 4,
  parameter int N_BIT_CMD_HEAD_FLIT  = 3
) (
  input logic               clk,
  input logic               rst,
  on_the_fly_table_if.slave bus
);
  localparam logic [N_BITS_POINTER:0]   L_FULL    = (N_BITS_POINTER+1)'(N_ENTRIES);
  localparam logic [N_BITS_TIMEOUT-1:0] L_AGE_MAX = '1;

  logic                            r_valid     [N_ENTRIES];
  logic [N_BIT_SRC_HEAD_FLIT-1:0]  r_sender    [N_ENTRIES];
  logic [N_BIT_DEST_HEAD_FLIT-1:0] r_recipient [N_ENTRIES];
  logic [N_BIT_CMD_HEAD_FLIT-1:0]  r_type      [N_ENTRIES];
  logic [N_BITS_TIMEOUT-1:0]       r_age       [N_ENTRIES];
  logic [N_BITS_POINTER:0]         r_count;
  logic                            r_hit;
  logic                            r_overflow;
  logic                            r_spurious;
  logic                            r_timeout;
  logic [N_BIT_SRC_HEAD_FLIT-1:0]  r_to_sender;
  logic [N_BIT_DEST_HEAD_FLIT-1:0] r_to_recipient;

  logic                      w_any_match;
  logic                      w_full;
  logic                      w_accept;
  logic                      w_retire;
  logic                      w_expire;
  logic [N_BITS_POINTER-1:0] w_alloc_idx;
  logic [N_BITS_POINTER-1:0] w_ret_idx;
  logic [N_BITS_POINTER-1:0] w_exp_idx;
  logic [N_BITS_POINTER:0]   w_count_next;

  // Descending scans so the lowest index is the one left standing.
  always_comb begin
    w_any_match = 1'b0;
    w_alloc_idx = '0;
    w_ret_idx   = '0;
    w_exp_idx   = '0;
    w_expire    = 1'b0;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_sender[i] == bus.query_sender_i &&
          r_recipient[i] == bus.query_recipient_i && r_type[i] == bus.query_type_i) begin
        w_any_match = 1'b1;
        w_ret_idx   = N_BITS_POINTER'(i);
      end
      if (!r_valid[i]) w_alloc_idx = N_BITS_POINTER'(i);
    end
    w_retire = bus.pending_transaction_executed_i && w_any_match;
    for (int i = N_ENTRIES - 1; i >= 0; i--) begin
      if (r_valid[i] && r_age[i] == L_AGE_MAX &&
          !(w_retire && w_ret_idx == N_BITS_POINTER'(i))) begin
        w_expire  = 1'b1;
        w_exp_idx = N_BITS_POINTER'(i);
      end
    end
    w_full       = (r_count == L_FULL);
    w_accept     = bus.insert_i && !w_full;
    w_count_next = r_count + (N_BITS_POINTER+1)'(w_accept)
                 - (N_BITS_POINTER+1)'(w_retire) - (N_BITS_POINTER+1)'(w_expire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        r_valid[i]     <= 1'b0;
        r_sender[i]    <= '0;
        r_recipient[i] <= '0;
        r_type[i]      <= '0;
        r_age[i]       <= '0;
      end
      r_count        <= '0;
      r_hit          <= 1'b0;
      r_overflow     <= 1'b0;
      r_spurious     <= 1'b0;
      r_timeout      <= 1'b0;
      r_to_sender    <= '0;
      r_to_recipient <= '0;
    end else begin
      for (int i = 0; i < N_ENTRIES; i++) begin
        if (r_valid[i] && r_age[i] != L_AGE_MAX) r_age[i] <= r_age[i] + N_BITS_TIMEOUT'(1);
        if (w_retire && w_ret_idx == N_BITS_POINTER'(i)) r_valid[i] <= 1'b0;
        if (w_expire && w_exp_idx == N_BITS_POINTER'(i)) r_valid[i] <= 1'b0;
        // The free slot is never the retired or expired one, so these never collide.
        if (w_accept && w_alloc_idx == N_BITS_POINTER'(i)) begin
          r_valid[i]     <= 1'b1;
          r_age[i]       <= '0;
          r_sender[i]    <= bus.insert_sender_i;
          r_recipient[i] <= bus.insert_recipient_i;
          r_type[i]      <= bus.insert_type_i;
        end
      end
      r_count        <= w_count_next;
      r_hit          <= bus.query_i && w_any_match;
      r_overflow     <= bus.insert_i && w_full;
      r_spurious     <= bus.pending_transaction_executed_i && !w_any_match;
      r_timeout      <= w_expire;
      r_to_sender    <= w_expire ? r_sender[w_exp_idx] : '0;
      r_to_recipient <= w_expire ? r_recipient[w_exp_idx] : '0;
    end
  end

  assign bus.is_a_pending_transaction_o = r_hit;
  assign bus.full_o                     = w_full;
  assign bus.empty_o                    = (r_count == '0);
  assign bus.count_o                    = r_count;
  assign bus.overflow_o                 = r_overflow;
  assign bus.spurious_exec_o            = r_spurious;
  assign bus.timeout_o                  = r_timeout;
  assign bus.timeout_sender_o           = r_to_sender;
  assign bus.timeout_recipient_o        = r_to_recipient;
endmodule

// File: tb/tb_on_the_fly_table.sv
// tb/tb_on_the_fly_table.sv - directed bench for on_the_fly_table, default aging plus a short-timeout instance
module tb_on_the_fly_table;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  on_the_fly_table_if #(.N_BITS_POINTER(3)) bus_a ();
  on_the_fly_table_if #(.N_BITS_POINTER(3)) bus_b ();

  on_the_fly_table #(.N_BITS_TIMEOUT(8)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  on_the_fly_table #(.N_BITS_TIMEOUT(3)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  assign bus_b.insert_i                       = bus_a.insert_i;
  assign bus_b.insert_sender_i                = bus_a.insert_sender_i;
  assign bus_b.insert_recipient_i             = bus_a.insert_recipient_i;
  assign bus_b.insert_type_i                  = bus_a.insert_type_i;
  assign bus_b.query_i                        = bus_a.query_i;
  assign bus_b.query_sender_i                 = bus_a.query_sender_i;
  assign bus_b.query_recipient_i              = bus_a.query_recipient_i;
  assign bus_b.query_type_i                   = bus_a.query_type_i;
  assign bus_b.pending_transaction_executed_i = bus_a.pending_transaction_executed_i;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ins(input logic en, input logic [3:0] s, input logic [3:0] r, input logic [2:0] t);
    bus_a.insert_i = en; bus_a.insert_sender_i = s; bus_a.insert_recipient_i = r; bus_a.insert_type_i = t;
  endtask

  task automatic set_qry(input logic q, input logic ex, input logic [3:0] s, input logic [3:0] r, input logic [2:0] t);
    bus_a.query_i = q; bus_a.pending_transaction_executed_i = ex;
    bus_a.query_sender_i = s; bus_a.query_recipient_i = r; bus_a.query_type_i = t;
  endtask

  task automatic idle();
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    set_qry(1'b0, 1'b0, 4'd0, 4'd0, 3'd0);
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (bus_a.count_o !== 4'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", bus_a.count_o); end
    total++; if (bus_a.empty_o !== 1'b1 || bus_a.full_o !== 1'b0) begin bad++; $display("FAIL reset_empty_full got=%b%b exp=10", bus_a.empty_o, bus_a.full_o); end
    total++; if ({bus_a.is_a_pending_transaction_o, bus_a.overflow_o, bus_a.spurious_exec_o, bus_a.timeout_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_pulses got=%b%b%b%b exp=0000", bus_a.is_a_pending_transaction_o, bus_a.overflow_o, bus_a.spurious_exec_o, bus_a.timeout_o); end
    total++; if (bus_a.timeout_sender_o !== 4'd0 || bus_a.timeout_recipient_o !== 4'd0) begin bad++; $display("FAIL reset_to_fields got=%0d/%0d exp=0/0", bus_a.timeout_sender_o, bus_a.timeout_recipient_o); end
    total++; if (bus_b.count_o !== 4'd0 || bus_b.empty_o !== 1'b1) begin bad++; $display("FAIL reset_b got=%0d/%b exp=0/1", bus_b.count_o, bus_b.empty_o); end
  endtask

  task automatic test_insert_query();
    do_reset();
    set_ins(1'b1, 4'd1, 4'd5, 3'd2);
    tick();
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    set_qry(1'b1, 1'b0, 4'd1, 4'd5, 3'd2);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL query_hit got=%b exp=1", bus_a.is_a_pending_transaction_o); end
    total++; if (bus_a.count_o !== 4'd1 || bus_a.empty_o !== 1'b0) begin bad++; $display("FAIL insert_count got=%0d/%b exp=1/0", bus_a.count_o, bus_a.empty_o); end
    set_qry(1'b1, 1'b0, 4'd1, 4'd5, 3'd3);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL query_wrong_type got=%b exp=0", bus_a.is_a_pending_transaction_o); end
    set_qry(1'b0, 1'b0, 4'd1, 4'd5, 3'd2);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL query_idle got=%b exp=0", bus_a.is_a_pending_transaction_o); end
  endtask

  task automatic test_same_cycle();
    do_reset();
    set_ins(1'b1, 4'd1, 4'd5, 3'd2);
    set_qry(1'b1, 1'b0, 4'd1, 4'd5, 3'd2);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL no_bypass got=%b exp=0", bus_a.is_a_pending_transaction_o); end
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL repeat_query got=%b exp=1", bus_a.is_a_pending_transaction_o); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_ins(1'b1, 4'(i), 4'(i), 3'(i));
      tick();
    end
    total++; if (bus_a.count_o !== 4'd8 || bus_a.full_o !== 1'b1 || bus_a.overflow_o !== 1'b0) begin
      bad++; $display("FAIL fill got=%0d/%b/%b exp=8/1/0", bus_a.count_o, bus_a.full_o, bus_a.overflow_o); end
    set_ins(1'b1, 4'd9, 4'd9, 3'd1);
    tick();
    total++; if (bus_a.overflow_o !== 1'b1 || bus_a.count_o !== 4'd8) begin bad++; $display("FAIL overflow got=%b/%0d exp=1/8", bus_a.overflow_o, bus_a.count_o); end
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    tick();
    total++; if (bus_a.overflow_o !== 1'b0) begin bad++; $display("FAIL overflow_pulse got=%b exp=0", bus_a.overflow_o); end
    set_ins(1'b1, 4'd9, 4'd9, 3'd1);
    set_qry(1'b0, 1'b1, 4'd3, 4'd3, 3'd3);
    tick();
    total++; if (bus_a.count_o !== 4'd7 || bus_a.full_o !== 1'b0 || bus_a.overflow_o !== 1'b1 || bus_a.spurious_exec_o !== 1'b0) begin
      bad++; $display("FAIL retire_while_full got=%0d/%b/%b/%b exp=7/0/1/0", bus_a.count_o, bus_a.full_o, bus_a.overflow_o, bus_a.spurious_exec_o); end
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    set_qry(1'b1, 1'b0, 4'd9, 4'd9, 3'd1);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b0) begin bad++; $display("FAIL dropped_absent got=%b exp=0", bus_a.is_a_pending_transaction_o); end
    set_ins(1'b1, 4'd9, 4'd9, 3'd1);
    set_qry(1'b1, 1'b0, 4'd3, 4'd3, 3'd3);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b0 || bus_a.count_o !== 4'd8) begin
      bad++; $display("FAIL refill got=%b/%0d exp=0/8", bus_a.is_a_pending_transaction_o, bus_a.count_o); end
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    set_qry(1'b1, 1'b0, 4'd9, 4'd9, 3'd1);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL refill_query got=%b exp=1", bus_a.is_a_pending_transaction_o); end
  endtask

  task automatic test_duplicate();
    do_reset();
    set_ins(1'b1, 4'd2, 4'd7, 3'd4);
    tick();
    tick();
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    total++; if (bus_a.count_o !== 4'd2) begin bad++; $display("FAIL dup_count got=%0d exp=2", bus_a.count_o); end
    set_qry(1'b0, 1'b1, 4'd2, 4'd7, 3'd4);
    tick();
    total++; if (bus_a.count_o !== 4'd1 || bus_a.spurious_exec_o !== 1'b0) begin bad++; $display("FAIL dup_retire got=%0d/%b exp=1/0", bus_a.count_o, bus_a.spurious_exec_o); end
    set_qry(1'b1, 1'b0, 4'd2, 4'd7, 3'd4);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b1) begin bad++; $display("FAIL dup_still_there got=%b exp=1", bus_a.is_a_pending_transaction_o); end
    set_qry(1'b0, 1'b1, 4'd6, 4'd6, 3'd6);
    tick();
    total++; if (bus_a.spurious_exec_o !== 1'b1 || bus_a.count_o !== 4'd1) begin bad++; $display("FAIL spurious got=%b/%0d exp=1/1", bus_a.spurious_exec_o, bus_a.count_o); end
    set_qry(1'b0, 1'b1, 4'd2, 4'd7, 3'd4);
    tick();
    total++; if (bus_a.spurious_exec_o !== 1'b0 || bus_a.count_o !== 4'd0 || bus_a.empty_o !== 1'b1) begin
      bad++; $display("FAIL dup_drain got=%b/%0d/%b exp=0/0/1", bus_a.spurious_exec_o, bus_a.count_o, bus_a.empty_o); end
  endtask

  task automatic test_timeout();
    logic exp_to;
    do_reset();
    set_ins(1'b1, 4'd3, 4'd6, 3'd5);
    tick();
    tick();
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    total++; if (bus_b.count_o !== 4'd2) begin bad++; $display("FAIL to_count_start got=%0d exp=2", bus_b.count_o); end
    for (int t = 2; t <= 10; t++) begin
      tick();
      exp_to = (t == 8 || t == 9);
      total++; if (bus_b.timeout_o !== exp_to) begin bad++; $display("FAIL timeout_edge%0d got=%b exp=%b", t, bus_b.timeout_o, exp_to); end
      if (exp_to) begin
        total++; if (bus_b.timeout_sender_o !== 4'd3 || bus_b.timeout_recipient_o !== 4'd6) begin
          bad++; $display("FAIL timeout_fields%0d got=%0d/%0d exp=3/6", t, bus_b.timeout_sender_o, bus_b.timeout_recipient_o); end
      end
      if (t == 8) begin
        total++; if (bus_b.count_o !== 4'd1) begin bad++; $display("FAIL to_count_mid got=%0d exp=1", bus_b.count_o); end
      end
    end
    total++; if (bus_b.count_o !== 4'd0 || bus_b.empty_o !== 1'b1) begin bad++; $display("FAIL to_drained got=%0d/%b exp=0/1", bus_b.count_o, bus_b.empty_o); end
  endtask

  task automatic test_retire_beats_expiry();
    do_reset();
    set_ins(1'b1, 4'd4, 4'd1, 3'd0);
    tick();
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    for (int t = 1; t <= 7; t++) tick();
    set_qry(1'b0, 1'b1, 4'd4, 4'd1, 3'd0);
    tick();
    total++; if (bus_b.timeout_o !== 1'b0 || bus_b.spurious_exec_o !== 1'b0 || bus_b.count_o !== 4'd0) begin
      bad++; $display("FAIL retire_wins got=%b/%b/%0d exp=0/0/0", bus_b.timeout_o, bus_b.spurious_exec_o, bus_b.count_o); end
    idle();
    tick();
    total++; if (bus_b.timeout_o !== 1'b0) begin bad++; $display("FAIL retire_wins_after got=%b exp=0", bus_b.timeout_o); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_ins(1'b1, 4'(i + 8), 4'(i), 3'(i));
      tick();
    end
    total++; if (bus_a.count_o !== 4'd4) begin bad++; $display("FAIL mid_fill got=%0d exp=4", bus_a.count_o); end
    rst = 1'b1;
    set_ins(1'b1, 4'd15, 4'd15, 3'd7);
    set_qry(1'b1, 1'b1, 4'd8, 4'd0, 3'd0);
    tick();
    rst = 1'b0;
    total++; if (bus_a.count_o !== 4'd0 || bus_a.empty_o !== 1'b1 || bus_a.full_o !== 1'b0) begin
      bad++; $display("FAIL mid_reset_count got=%0d/%b/%b exp=0/1/0", bus_a.count_o, bus_a.empty_o, bus_a.full_o); end
    total++; if ({bus_a.is_a_pending_transaction_o, bus_a.overflow_o, bus_a.spurious_exec_o, bus_a.timeout_o} !== 4'b0000) begin
      bad++; $display("FAIL mid_reset_pulses got=%b%b%b%b exp=0000", bus_a.is_a_pending_transaction_o, bus_a.overflow_o, bus_a.spurious_exec_o, bus_a.timeout_o); end
    set_ins(1'b0, 4'd0, 4'd0, 3'd0);
    set_qry(1'b1, 1'b0, 4'd8, 4'd0, 3'd0);
    tick();
    total++; if (bus_a.is_a_pending_transaction_o !== 1'b0 || bus_a.count_o !== 4'd0) begin
      bad++; $display("FAIL mid_reset_query got=%b/%0d exp=0/0", bus_a.is_a_pending_transaction_o, bus_a.count_o); end
  endtask

  initial begin
    idle();
    test_reset();
    test_insert_query();
    test_same_cycle();
    test_full();
    test_duplicate();
    test_timeout();
    test_retire_beats_expiry();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
